// File: rtl/pipe_pkg.sv
// Shared pipeline payload layout: field widths, bit offsets and control-bit positions.
// Stages stay payload-agnostic and size themselves from STAGE_WIDTH.
package pipe_pkg;

  localparam int XLEN        = 32;
  localparam int VPC_BITS    = 20;
  localparam int RD_BITS     = 5;
  localparam int ALU_OP_BITS = 4;
  localparam int CTRL_BITS   = 3;

  // Fields are packed LSB-first: ctrl, aluOp, rd, vpc, result.
  localparam int CTRL_LSB   = 0;
  localparam int ALU_OP_LSB = CTRL_LSB + CTRL_BITS;
  localparam int RD_LSB     = ALU_OP_LSB + ALU_OP_BITS;
  localparam int VPC_LSB    = RD_LSB + RD_BITS;
  localparam int XLEN_LSB   = VPC_LSB + VPC_BITS;

  localparam int STAGE_WIDTH = XLEN_LSB + XLEN;

  localparam int CTRL_IS_BRANCH = 0;
  localparam int CTRL_WB_EN     = 1;
  localparam int CTRL_MEM_EN    = 2;

  typedef struct packed {
    logic [XLEN-1:0]        result;
    logic [VPC_BITS-1:0]    vpc;
    logic [RD_BITS-1:0]     rd;
    logic [ALU_OP_BITS-1:0] aluOp;
    logic [CTRL_BITS-1:0]   ctrl;
  } stage_fields_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage's stall and bubble statistics.
module pipe_sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  // Sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with hold (stall), flush (kill) and
// saturating stall/bubble counters. Entry order is strictly FIFO: main, then skid.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH       = STAGE_WIDTH,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  input  logic                hold,
  input  logic                flush,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] bubble_cnt
);

  logic             mainValid_q, mainValid_d;
  logic [WIDTH-1:0] mainData_q,  mainData_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q,  skidData_d;

  logic accept;
  logic consume;

  // Ready is purely combinational from the skid flag so upstream sees a full skid immediately.
  assign in_ready = !skidValid_q && !hold && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = mainValid_q && out_ready;

  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;

    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
      if (ZERO_BUBBLE) begin
        mainData_d = '0;
        skidData_d = '0;
      end
    end else if (!mainValid_q || consume) begin
      // Main is free this cycle: the skid entry is older than anything arriving now.
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainData_d  = skidData_q;
        skidValid_d = 1'b0;
        if (ZERO_BUBBLE) begin
          skidData_d = '0;
        end
      end else if (accept) begin
        mainValid_d = 1'b1;
        mainData_d  = in_data;
      end else begin
        mainValid_d = 1'b0;
        if (ZERO_BUBBLE) begin
          mainData_d = '0;
        end
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end

  assign out_valid = mainValid_q;
  assign out_data  = mainData_q;

  logic stallInc;
  logic bubbleInc;

  assign stallInc  = mainValid_q && !out_ready;
  assign bubbleInc = !mainValid_q;

  pipe_sat_counter #(.CNT_BITS(CNT_BITS)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_BITS(CNT_BITS)) uBubbleCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubbleInc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic, checked against
// a queue-based model of a two-deep FIFO stage with saturating statistics.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int W = STAGE_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, inValid, outReady, hold, flush;
  logic [W-1:0] inData;
  logic         inReady, outValid;
  logic [W-1:0] outData;
  logic [15:0]  stallCnt, bubbleCnt;

  logic         satInReady, satOutValid;
  logic [W-1:0] satOutData;
  logic [3:0]   satStall, satBubble;

  pipe_skid_stage #(.WIDTH(W), .ZERO_BUBBLE(1'b1), .CNT_BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_data    (inData),
    .in_ready   (inReady),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_ready  (outReady),
    .hold       (hold),
    .flush      (flush),
    .stall_cnt  (stallCnt),
    .bubble_cnt (bubbleCnt)
  );

  // Narrow-counter twin driven identically, used to observe saturation.
  pipe_skid_stage #(.WIDTH(W), .ZERO_BUBBLE(1'b1), .CNT_BITS(4)) dutSat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_data    (inData),
    .in_ready   (satInReady),
    .out_valid  (satOutValid),
    .out_data   (satOutData),
    .out_ready  (outReady),
    .hold       (hold),
    .flush      (flush),
    .stall_cnt  (satStall),
    .bubble_cnt (satBubble)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] modelQ[$];
  int unsigned  mStall = 0, mBubble = 0, mStallSat = 0, mBubbleSat = 0;
  bit           checkEnable = 1'b0;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int unsigned satInc(input int unsigned v, input int unsigned maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, then advance the model on the edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [W-1:0] d,
                               input logic ordy, input logic h, input logic f);
    logic         mOutValid;
    logic [W-1:0] mOutData;
    logic         mInReady;
    rst = r; inValid = iv; inData = d; outReady = ordy; hold = h; flush = f;
    @(negedge clk);
    mOutValid = (modelQ.size() > 0);
    mOutData  = mOutValid ? modelQ[0] : '0;
    mInReady  = (modelQ.size() < 2) && !h && !f;
    if (checkEnable) begin
      checkOutput("outValid",    W'(outValid),    W'(mOutValid));
      checkOutput("outData",     outData,         mOutData);
      checkOutput("inReady",     W'(inReady),     W'(mInReady));
      checkOutput("stallCnt",    W'(stallCnt),    W'(mStall));
      checkOutput("bubbleCnt",   W'(bubbleCnt),   W'(mBubble));
      checkOutput("satOutData",  satOutData,      mOutData);
      checkOutput("satStall",    W'(satStall),    W'(mStallSat));
      checkOutput("satBubble",   W'(satBubble),   W'(mBubbleSat));
    end
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      mStall = 0; mBubble = 0; mStallSat = 0; mBubbleSat = 0;
    end else begin
      if (mOutValid && !ordy) begin
        mStall    = satInc(mStall, 65535);
        mStallSat = satInc(mStallSat, 15);
      end
      if (!mOutValid) begin
        mBubble    = satInc(mBubble, 65535);
        mBubbleSat = satInc(mBubbleSat, 15);
      end
      if (f) begin
        modelQ.delete();
      end else begin
        if (mOutValid && ordy) void'(modelQ.pop_front());
        if (iv && mInReady) modelQ.push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  int unsigned base;
  logic [W-1:0] rnd;

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b0; hold = 1'b0; flush = 1'b0;

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEnable = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstOutValid", W'(outValid), '0);
    checkOutput("rstInReady",  W'(inReady),  W'(1'b1));
    idle(2, 1'b1);

    // Streaming 1,2,3 back to back.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, W'(k), 1'b1, 1'b0, 1'b0);
      checkOutput("streamData", outData, W'(k));
    end
    idle(2, 1'b1);

    // Backpressure: A in main, B into skid, then drain.
    base = mStall;
    applyStimulus(1'b0, 1'b1, W'(64'hA), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, W'(64'hB), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("bpInReady", W'(inReady), '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bpSecond", outData, W'(64'hB));
    checkOutput("bpStall",  W'(stallCnt), W'(base + 2));
    idle(2, 1'b1);

    // Flush with both entries full while 0xC is offered.
    applyStimulus(1'b0, 1'b1, W'(64'h11), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, W'(64'h12), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, W'(64'hC), 1'b1, 1'b0, 1'b1);
    checkOutput("flushValid", W'(outValid), '0);
    checkOutput("flushData",  outData, '0);
    idle(3, 1'b1);

    // Hold for three cycles from empty, then release.
    base = mBubble;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, W'(64'h55), 1'b1, 1'b1, 1'b0);
    checkOutput("holdBubble", W'(bubbleCnt), W'(base + 3));
    applyStimulus(1'b0, 1'b1, W'(64'h55), 1'b1, 1'b0, 1'b0);
    checkOutput("holdRelValid", W'(outValid), W'(1'b1));
    checkOutput("holdRelData",  outData, W'(64'h55));

    // Saturation of the 4-bit bubble counter.
    idle(20, 1'b1);
    checkOutput("satStop", W'(satBubble), W'(4'hF));

    // Reset mid-operation with both entries full.
    applyStimulus(1'b0, 1'b1, W'(64'h31), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, W'(64'h32), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, W'(64'h33), 1'b1, 1'b1, 1'b1);
    rst = 1'b0; hold = 1'b0; flush = 1'b0; inValid = 1'b0;
    #1;
    checkOutput("midRstValid",  W'(outValid),  '0);
    checkOutput("midRstStall",  W'(stallCnt),  '0);
    checkOutput("midRstBubble", W'(bubbleCnt), '0);
    checkOutput("midRstReady",  W'(inReady),   W'(1'b1));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 1) == 1,
                    rnd,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
